mtx_ph_seq_mc: RTL and testbench
================================

# mtx_ph_seq_mc

Multi-channel phase sequencer for the multitone transmit path. It generates time-interleaved phase words for NCH channels, one beat per channel per sample. Each symbol of a frame uses a stepped frequency, and each channel carries a fixed frequency offset from channel 0. The AXI-stream output feeds a downstream sin/cos stage. Over a single-channel phase generator, it adds runtime-configurable frame geometry, per-channel offsets, one-shot/continuous modes, clean stop at frame boundary, and full output backpressure.

## Interface
- PHASE_WIDTH, 24, phase accumulator and increment width
- NSIG_WIDTH, 24, samples-per-symbol counter width
- NSYMB_WIDTH, 16, symbol counter width
- NCH, 4, channel count (≥1)
- CH_WIDTH, 2, channel index width, = max(1, clog2(NCH))

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- srst  in  1  synchronous reset, same effect as reset, active-high
- start  in  1  pulse; begins a frame when IDLE, ignored otherwise
- stop  in  1  pulse; requests halt at end of current frame
- mode_cont  in  1  1 = continuous frames, 0 = one-shot; sampled in LOAD
- cfg_base_inc  in  PHASE_WIDTH  channel-0 increment for symbol 0
- cfg_symb_step  in  PHASE_WIDTH  increment added per symbol
- cfg_ch_step  in  PHASE_WIDTH  increment offset per channel
- cfg_nsamp  in  NSIG_WIDTH  samples per symbol; 0 is treated as 1
- cfg_nsymb  in  NSYMB_WIDTH  symbols per frame; 0 is treated as 1
- out_tdata  out  PHASE_WIDTH  phase word
- out_tuser  out  CH_WIDTH  channel index of the beat
- out_tvalid  out  1  beat valid
- out_tready  in  1  downstream ready
- out_tlast  out  1  last beat of frame
- ph_start  out  PHASE_WIDTH  channel-0 phase at first sample of current symbol
- sigN  out  NSIG_WIDTH  current sample index within the symbol
- symbN  out  NSYMB_WIDTH  current symbol index
- busy  out  1  high in LOAD or RUN

## Operation
- States are IDLE, LOAD and RUN.
- IDLE→LOAD on start. LOAD→RUN always, after one cycle.
- RUN→IDLE on acceptance of the tlast beat, if one-shot or a stop is pending.
- LOAD latches all cfg_* values and mode_cont, and clears the stop-pending flag.
- LOAD sets inc[c] = cfg_base_inc + c·cfg_ch_step, ph[c] = 0 for every c, counters = 0, and ph_start = 0.
- Beat order is channel fastest, then sample, then symbol. Beat (n, c) has out_tdata = ph[c] and out_tuser = c.
- On acceptance (out_tvalid & out_tready), ph[c] += inc[c], and the channel counter advances.
- After channel NCH-1 is accepted, the channel counter returns to 0 and sigN increments.
- After the last sample of a symbol (sigN = nsamp-1, channel NCH-1) is accepted:
  - sigN wraps to 0 and symbN increments.
  - Every inc[c] += cfg_symb_step.
  - ph_start takes the updated ph[0].
- out_tlast = (symbN = nsymb-1) & (sigN = nsamp-1) & (channel = NCH-1).
- Continuous mode, at end of frame:
  - symbN wraps to 0, and inc[c] reloads to base + c·ch_step.
  - ph[c] is not reset, so phase stays continuous across frames.
- stop during LOAD or RUN sets stop-pending. The frame completes and the block returns to IDLE. stop in IDLE is ignored.
- All adds are modulo 2^PHASE_WIDTH. No saturation.
- Counter compares use the latched, zero-corrected cfg values.

## Timing
- Values on reset or srst:
  - State IDLE; out_tvalid, out_tlast, out_tdata, out_tuser = 0.
  - ph_start, sigN, symbN, busy = 0; stop-pending cleared.
- reset acts immediately. srst acts at the next edge and takes priority over start and stop in the same cycle.
- Start latency: start sampled at edge k gives LOAD in cycle k+1. out_tvalid is high from edge k+2 and the first beat is presented then.
- In RUN, out_tvalid stays high continuously. out_tdata, out_tuser and out_tlast hold while out_tvalid & !out_tready.
- Throughput is one beat per clock when out_tready = 1.
- After the final beat is accepted at edge m, the block is in IDLE with out_tvalid = 0 and busy = 0 from edge m+1.
- A start in that same cycle is ignored.
- All outputs are registered. There is no combinational path from out_tready to out_tvalid.
- Changes to cfg_* during RUN have no effect until the next LOAD.

## Test plan
Default config for scenarios 1–4: NCH=4, cfg_base_inc=0x001000, cfg_ch_step=0x000100, cfg_symb_step=0x010000, cfg_nsamp=4, cfg_nsymb=3.

1. One-shot, out_tready=1 → exactly 48 beats.
   - Beats 0–3: tdata 0, tuser 0..3.
   - Beats 4–7: 0x001000, 0x001100, 0x001200, 0x001300.
   - tlast only on beat 47; busy falls the cycle after.
2. Symbol boundary → beat 16 has tdata 0x004000 and tuser 0, with ph_start = 0x004000 and symbN = 1. Beat 20 has tdata 0x015000.
3. Random out_tready at 30% → data is held stable while stalled, and the accepted sequence is identical to scenario 1.
4. Continuous mode, stop pulsed at beat 60 → tlast on beats 47 and 95.
   - Beat 48 tdata = 0x0CC000 (phase continuous across frames).
   - IDLE after beat 95.
5. cfg_base_inc=0xFFF000, cfg_symb_step=0, cfg_nsamp=4 → ch0 sequence 0x000000, 0xFFF000, 0xFFE000, 0xFFD000 (wrap modulo 2^24).
   - cfg_nsamp=0 and cfg_nsymb=0 together → one sample of one symbol, 4 beats, tlast on beat 3.
6. Resets mid-frame:
   - srst at beat 20 → the next edge gives tvalid=0, counters 0, IDLE.
   - A subsequent start restarts from tdata 0.
   - Asynchronous reset mid-cycle → outputs 0 before the next edge.

Source files
------------

// File: rtl/mtx_ph_seq_mc.sv
// Multi-channel phase sequencer: time-interleaved phase words for NCH channels
// with per-symbol stepped frequency, per-channel offsets and AXI-stream backpressure.
module mtx_ph_seq_mc #(
  parameter int PHASE_WIDTH = 24,
  parameter int NSIG_WIDTH  = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int NCH         = 4,
  parameter int CH_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   srst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode_cont,
  input  logic [PHASE_WIDTH-1:0] cfg_base_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_symb_step,
  input  logic [PHASE_WIDTH-1:0] cfg_ch_step,
  input  logic [NSIG_WIDTH-1:0]  cfg_nsamp,
  input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
  output logic [PHASE_WIDTH-1:0] out_tdata,
  output logic [CH_WIDTH-1:0]    out_tuser,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic                   out_tlast,
  output logic [PHASE_WIDTH-1:0] ph_start,
  output logic [NSIG_WIDTH-1:0]  sigN,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d, stop_pend_q, stop_pend_d;
  logic [PHASE_WIDTH-1:0] base_q, base_d, symb_step_q, symb_step_d, ch_step_q, ch_step_d;
  logic [NSIG_WIDTH-1:0]  nsamp_q, nsamp_d, nsamp_c, sig_q, sig_d;
  logic [NSYMB_WIDTH-1:0] nsymb_q, nsymb_d, nsymb_c, symb_q, symb_d;
  logic [PHASE_WIDTH-1:0] inc_q [NCH];
  logic [PHASE_WIDTH-1:0] inc_d [NCH];
  logic [PHASE_WIDTH-1:0] ph_q  [NCH];
  logic [PHASE_WIDTH-1:0] ph_d  [NCH];
  logic [CH_WIDTH-1:0]    ch_q, ch_d, tuser_q, tuser_d;
  logic [PHASE_WIDTH-1:0] ph_start_q, ph_start_d, tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d;
  logic                   acc, last_ch, last_samp, last_symb, halt;

  function automatic logic [PHASE_WIDTH-1:0] ch_inc(input logic [PHASE_WIDTH-1:0] base,
                                                    input logic [PHASE_WIDTH-1:0] step,
                                                    input int c);
    return base + step * PHASE_WIDTH'(c);
  endfunction

  assign nsamp_c   = (cfg_nsamp == '0) ? NSIG_WIDTH'(1) : cfg_nsamp;
  assign nsymb_c   = (cfg_nsymb == '0) ? NSYMB_WIDTH'(1) : cfg_nsymb;
  assign acc       = tvalid_q & out_tready;
  assign last_ch   = (ch_q == CH_WIDTH'(NCH - 1));
  assign last_samp = (sig_q == nsamp_q - NSIG_WIDTH'(1));
  assign last_symb = (symb_q == nsymb_q - NSYMB_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    base_d      = base_q;
    symb_step_d = symb_step_q;
    ch_step_d   = ch_step_q;
    nsamp_d     = nsamp_q;
    nsymb_d     = nsymb_q;
    inc_d       = inc_q;
    ph_d        = ph_q;
    ch_d        = ch_q;
    sig_d       = sig_q;
    symb_d      = symb_q;
    ph_start_d  = ph_start_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    halt        = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        mode_d      = mode_cont;
        stop_pend_d = stop;
        base_d      = cfg_base_inc;
        symb_step_d = cfg_symb_step;
        ch_step_d   = cfg_ch_step;
        nsamp_d     = nsamp_c;
        nsymb_d     = nsymb_c;
        for (int c = 0; c < NCH; c++) begin
          inc_d[c] = ch_inc(cfg_base_inc, cfg_ch_step, c);
          ph_d[c]  = '0;
        end
        ch_d       = '0;
        sig_d      = '0;
        symb_d     = '0;
        ph_start_d = '0;
        tvalid_d   = 1'b1;
        tdata_d    = '0;
        tuser_d    = '0;
        tlast_d    = (nsymb_c == NSYMB_WIDTH'(1)) && (nsamp_c == NSIG_WIDTH'(1)) && (NCH == 1);
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (acc) begin
          ph_d[ch_q] = ph_q[ch_q] + inc_q[ch_q];
          if (!last_ch) begin
            ch_d = ch_q + CH_WIDTH'(1);
          end else begin
            ch_d  = '0;
            sig_d = last_samp ? '0 : sig_q + NSIG_WIDTH'(1);
            if (last_samp) begin
              ph_start_d = ph_d[0];
              for (int c = 0; c < NCH; c++) inc_d[c] = inc_q[c] + symb_step_q;
              if (!last_symb) begin
                symb_d = symb_q + NSYMB_WIDTH'(1);
              end else begin
                symb_d = '0;
                // Continuous frames keep ph[] running; only the increments restart
                if (!mode_q || stop_pend_q || stop) halt = 1'b1;
                else for (int c = 0; c < NCH; c++) inc_d[c] = ch_inc(base_q, ch_step_q, c);
              end
            end
          end
          if (halt) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
            tvalid_d    = 1'b0;
            tdata_d     = '0;
            tuser_d     = '0;
            tlast_d     = 1'b0;
          end else begin
            tdata_d = ph_d[ch_d];
            tuser_d = ch_d;
            tlast_d = (symb_d == nsymb_q - NSYMB_WIDTH'(1)) &&
                      (sig_d == nsamp_q - NSIG_WIDTH'(1)) && (ch_d == CH_WIDTH'(NCH - 1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (srst) begin
      state_d     = S_IDLE;
      stop_pend_d = 1'b0;
      ch_d        = '0;
      sig_d       = '0;
      symb_d      = '0;
      ph_start_d  = '0;
      tvalid_d    = 1'b0;
      tdata_d     = '0;
      tuser_d     = '0;
      tlast_d     = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      ch_q        <= '0;
      sig_q       <= '0;
      symb_q      <= '0;
      ph_start_q  <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
      ch_q        <= ch_d;
      sig_q       <= sig_d;
      symb_q      <= symb_d;
      ph_start_q  <= ph_start_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
    end
  end

  // Datapath state is always rewritten in LOAD, so it carries no reset
  always_ff @(posedge clk) begin
    base_q      <= base_d;
    symb_step_q <= symb_step_d;
    ch_step_q   <= ch_step_d;
    nsamp_q     <= nsamp_d;
    nsymb_q     <= nsymb_d;
    for (int c = 0; c < NCH; c++) begin
      inc_q[c] <= inc_d[c];
      ph_q[c]  <= ph_d[c];
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tuser  = tuser_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign ph_start   = ph_start_q;
  assign sigN       = sig_q;
  assign symbN      = symb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mtx_ph_seq_mc.sv
// Bench for mtx_ph_seq_mc: directed scenarios plus random backpressure/config,
// checked against a loop-based frame model of the phase sequence.
module tb_mtx_ph_seq_mc;
  localparam int PW = 24, NW = 24, SW = 16, NCH = 4, CW = 2;

  logic clk = 1'b0;
  logic reset, srst, start, stop, mode_cont, out_tready;
  logic [PW-1:0] cfg_base_inc, cfg_symb_step, cfg_ch_step;
  logic [NW-1:0] cfg_nsamp;
  logic [SW-1:0] cfg_nsymb;
  logic [PW-1:0] out_tdata, ph_start;
  logic [CW-1:0] out_tuser;
  logic out_tvalid, out_tlast, busy;
  logic [NW-1:0] sigN;
  logic [SW-1:0] symbN;

  mtx_ph_seq_mc #(.PHASE_WIDTH(PW), .NSIG_WIDTH(NW), .NSYMB_WIDTH(SW), .NCH(NCH), .CH_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .srst(srst), .start(start), .stop(stop), .mode_cont(mode_cont),
    .cfg_base_inc(cfg_base_inc), .cfg_symb_step(cfg_symb_step), .cfg_ch_step(cfg_ch_step),
    .cfg_nsamp(cfg_nsamp), .cfg_nsymb(cfg_nsymb), .out_tdata(out_tdata), .out_tuser(out_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast), .ph_start(ph_start),
    .sigN(sigN), .symbN(symbN), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] d;
    logic [CW-1:0] u;
    logic          l;
    logic [PW-1:0] ps;
    logic [NW-1:0] sg;
    logic [SW-1:0] sy;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [PW-1:0] b, input logic [PW-1:0] ss, input logic [PW-1:0] cs,
                         input logic [NW-1:0] ns, input logic [SW-1:0] nsy);
    cfg_base_inc = b; cfg_symb_step = ss; cfg_ch_step = cs; cfg_nsamp = ns; cfg_nsymb = nsy;
  endtask

  // Expected beats: frame, symbol, sample, channel order; channel c in symbol s
  // advances by base + c*ch_step + s*symb_step, and phases never reset between frames.
  task automatic build_exp(input logic [PW-1:0] b, input logic [PW-1:0] ss, input logic [PW-1:0] cs,
                           input int ns, input int nsy, input int nfr);
    logic [PW-1:0] ph [NCH];
    logic [PW-1:0] inc, ps;
    beat_t bt;
    int nse, nsye;
    nse  = (ns == 0) ? 1 : ns;
    nsye = (nsy == 0) ? 1 : nsy;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) ph[c] = '0;
    ps = '0;
    for (int f = 0; f < nfr; f++)
      for (int s = 0; s < nsye; s++) begin
        ps = ph[0];
        for (int n = 0; n < nse; n++)
          for (int c = 0; c < NCH; c++) begin
            bt.d = ph[c]; bt.u = CW'(c);
            bt.l = (s == nsye - 1) && (n == nse - 1) && (c == NCH - 1);
            bt.ps = ps; bt.sg = NW'(n); bt.sy = SW'(s);
            exp_q.push_back(bt);
            inc = b + cs * PW'(c) + ss * PW'(s);
            ph[c] = ph[c] + inc;
          end
      end
  endtask

  task automatic run(input string tag, input bit cont, input int stop_at, input int pct,
                     input bit scramble, input int srst_at);
    int cyc;
    bit stalled, acc, hit_srst, last_acc_tlast;
    logic [PW-1:0] hd;
    logic [CW-1:0] hu;
    logic hl;
    beat_t bt;
    got.delete();
    mode_cont = cont;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_load_busy"}, busy, 1);
    check({tag, "_load_tvalid"}, out_tvalid, 0);
    cyc = 0; stalled = 0; hit_srst = 0; last_acc_tlast = 0;
    hd = '0; hu = '0; hl = 1'b0;
    while (busy && !hit_srst && cyc < 3000) begin
      cyc++;
      if (out_tvalid && stalled)
        check({tag, "_stall_hold"}, {out_tdata, out_tuser, out_tlast}, {hd, hu, hl});
      out_tready = ($urandom_range(99) < pct);
      acc = out_tvalid && out_tready;
      stop = acc && (got.size() == stop_at);
      srst = out_tvalid && (got.size() == srst_at);
      start = acc && out_tlast;
      if (acc) begin
        bt.d = out_tdata; bt.u = out_tuser; bt.l = out_tlast;
        bt.ps = ph_start; bt.sg = sigN; bt.sy = symbN;
        got.push_back(bt);
      end
      last_acc_tlast = acc && out_tlast;
      stalled = out_tvalid && !out_tready;
      hd = out_tdata; hu = out_tuser; hl = out_tlast;
      if (scramble && out_tvalid)
        set_cfg(PW'($urandom), PW'($urandom), PW'($urandom), NW'($urandom_range(9)), SW'($urandom_range(9)));
      hit_srst = srst;
      step();
      stop = 1'b0; start = 1'b0; srst = 1'b0;
    end
    check({tag, "_bounded"}, cyc < 3000, 1);
    if (hit_srst) begin
      check({tag, "_srst_tvalid"}, out_tvalid, 0);
      check({tag, "_srst_cnt"}, {sigN, symbN, out_tdata}, 0);
      check({tag, "_srst_busy"}, busy, 0);
    end else begin
      check({tag, "_idle_after_tlast"}, last_acc_tlast, 1);
      check({tag, "_idle_tvalid"}, out_tvalid, 0);
      step();
      check({tag, "_start_ignored"}, busy, 0);
    end
    out_tready = 1'b1;
  endtask

  task automatic cmp(input string tag);
    check({tag, "_nbeats"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), {got[i].d, got[i].u, got[i].l},
            {exp_q[i].d, exp_q[i].u, exp_q[i].l});
      check($sformatf("%s_ctx%0d", tag, i), {got[i].ps, got[i].sg, got[i].sy},
            {exp_q[i].ps, exp_q[i].sg, exp_q[i].sy});
    end
  endtask

  initial begin
    reset = 1'b1; srst = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; out_tready = 1'b1;
    set_cfg(24'h001000, 24'h010000, 24'h000100, 4, 3);
    step(); step();
    reset = 1'b0;
    step();
    check("rst_out", {out_tvalid, out_tlast, out_tdata, out_tuser}, 0);
    check("rst_ctx", {ph_start, sigN, symbN, busy}, 0);

    // One-shot default frame with full throughput
    build_exp(24'h001000, 24'h010000, 24'h000100, 4, 3, 1);
    run("s1", 0, -1, 100, 0, -1);
    cmp("s1");
    check("s1_b5", got[5].d, 24'h001100);
    check("s1_b7", {got[7].d, got[7].u}, {24'h001300, 2'd3});
    check("s1_tlast47", {got[46].l, got[47].l}, 2'b01);
    check("s2_b16", {got[16].d, got[16].u, got[16].ps, got[16].sy}, {24'h004000, 2'd0, 24'h004000, 16'd1});
    check("s2_b20", got[20].d, 24'h015000);

    // Random backpressure with cfg churn during RUN
    build_exp(24'h001000, 24'h010000, 24'h000100, 4, 3, 1);
    run("s3", 0, -1, 30, 1, -1);
    cmp("s3");
    set_cfg(24'h001000, 24'h010000, 24'h000100, 4, 3);

    // Continuous frames, stop requested mid second frame
    build_exp(24'h001000, 24'h010000, 24'h000100, 4, 3, 2);
    run("s4", 1, 60, 100, 0, -1);
    cmp("s4");
    check("s4_b48", got[48].d, 24'h0CC000);
    check("s4_tlast", {got[47].l, got[95].l}, 2'b11);

    // Modulo wrap
    set_cfg(24'hFFF000, 24'h0, 24'h000100, 4, 3);
    build_exp(24'hFFF000, 24'h0, 24'h000100, 4, 3, 1);
    run("s5", 0, -1, 100, 0, -1);
    cmp("s5");
    check("s5_ch0", {got[4].d, got[8].d, got[12].d}, {24'hFFF000, 24'hFFE000, 24'hFFD000});

    // Zero geometry means one sample of one symbol
    set_cfg(24'h001000, 24'h010000, 24'h000100, 0, 0);
    build_exp(24'h001000, 24'h010000, 24'h000100, 0, 0, 1);
    run("s5z", 0, -1, 100, 0, -1);
    cmp("s5z");
    check("s5z_tlast3", got[3].l, 1);

    // Synchronous reset mid-frame, then a clean restart
    set_cfg(24'h001000, 24'h010000, 24'h000100, 4, 3);
    run("s6", 0, -1, 100, 0, 20);
    build_exp(24'h001000, 24'h010000, 24'h000100, 4, 3, 1);
    run("s6r", 0, -1, 100, 0, -1);
    cmp("s6r");

    // Random geometry and increments under random backpressure
    for (int k = 0; k < 3; k++) begin
      logic [PW-1:0] rb, rs, rc;
      int rn, rsy;
      rb = PW'($urandom); rs = PW'($urandom); rc = PW'($urandom);
      rn = $urandom_range(3, 1); rsy = $urandom_range(3, 1);
      set_cfg(rb, rs, rc, NW'(rn), SW'(rsy));
      build_exp(rb, rs, rc, rn, rsy, 1);
      run($sformatf("rnd%0d", k), 0, -1, 50, 0, -1);
      cmp($sformatf("rnd%0d", k));
    end

    // Asynchronous reset between edges
    set_cfg(24'h001000, 24'h010000, 24'h000100, 4, 3);
    mode_cont = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("arst_pre", {out_tvalid, busy}, 2'b11);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out", {out_tvalid, out_tlast, out_tdata, out_tuser, busy}, 0);
    check("arst_ctx", {ph_start, sigN, symbN}, 0);
    step();
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
